// File: rtl/transpose_pkg.sv
// transpose_pkg: shared FSM state type and default sizing for the transpose bank controller
package transpose_pkg;
  typedef enum logic {LOAD, DRAIN} state_t;
  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_NUM_PE = 8;
endpackage

// File: rtl/tranpose_memory_bank.sv
// tranpose_memory_bank: one element bank with a registered read and same-address write bypass
module tranpose_memory_bank #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  write_e,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // store writes; the read register forwards a write landing on the address being read
  always_ff @(posedge clk) begin
    if (write_e) mem[write_addr] <= write_data;
    read_data <= (write_e && write_addr == read_addr) ? write_data : mem[read_addr];
  end
endmodule

// File: rtl/transpose_bank_controller.sv
// transpose_bank_controller: buffers one NUM_PE x NUM_PE matrix in skewed banks and drains it column by column
module transpose_bank_controller
  import transpose_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_PE = DEFAULT_NUM_PE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_PE*DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_PE*DATA_WIDTH-1:0] out_data,
  output logic                         out_last
);
  localparam int ADDR_WIDTH = $clog2(NUM_PE);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_PE - 1);
  state_t state, state_next;
  logic [ADDR_WIDTH-1:0] r, c, c_next;
  logic accept, fire;
  logic [DATA_WIDTH-1:0] rd [NUM_PE];
  // handshakes, column advance and LOAD/DRAIN transitions; outputs are masked while in reset
  always_comb begin
    in_ready = state == LOAD && !rst;
    out_valid = state == DRAIN && !rst;
    out_last = out_valid && c == LAST;
    accept = in_valid && in_ready;
    fire = out_valid && out_ready;
    c_next = fire ? c + ADDR_WIDTH'(1) : c;
    state_next = (state == LOAD && accept && r == LAST) ? DRAIN : (fire && out_last) ? LOAD : state;
  end
  // state and the row/column counters; both counters wrap back to zero at the end of a matrix
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      r <= '0;
      c <= '0;
    end else begin
      state <= state_next;
      r <= accept ? r + ADDR_WIDTH'(1) : r;
      c <= c_next;
    end
  end
  genvar b;
  generate
    for (b = 0; b < NUM_PE; b++) begin : g_bank
      logic [ADDR_WIDTH-1:0] ra, ei, li;
      assign ra = ADDR_WIDTH'(b) - c_next;
      assign ei = ADDR_WIDTH'(b) - r;
      assign li = c + ADDR_WIDTH'(b);
      tranpose_memory_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
      ) u_bank (
        .clk(clk),
        .write_e(accept),
        .write_addr(state == DRAIN ? ~ra : r),
        .write_data(in_data[ei*DATA_WIDTH +: DATA_WIDTH]),
        .read_addr(ra),
        .read_data(rd[b])
      );
      assign out_data[b*DATA_WIDTH +: DATA_WIDTH] = rd[li];
    end
  endgenerate
endmodule

// File: doc/transpose_bank_controller.md
TRANSPOSE_BANK_CONTROLLER -- requirements
Module: transpose_bank_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, element width in bits.
REQ-002 SHALL have parameter NUM_PE, default 8, matrix dimension and bank count; power of two, >= 2.
REQ-003 SHALL have localparam ADDR_WIDTH = $clog2(NUM_PE).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  row beat valid.
REQ-007 SHALL have port in_ready  output  1  controller accepts a row this cycle.
REQ-008 SHALL have port in_data  input  NUM_PE*DATA_WIDTH  one matrix row; element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port out_valid  output  1  column beat valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts a column this cycle.
REQ-011 SHALL have port out_data  output  NUM_PE*DATA_WIDTH  one transposed column; lane k = row k.
REQ-012 SHALL have port out_last  output  1  asserted with out_valid on column NUM_PE-1.

Function
REQ-013 SHALL operate as a two-state FSM, LOAD and DRAIN; one matrix buffered at a time, with no overlap of load and drain.
REQ-014 In LOAD, SHALL drive in_ready=1 and out_valid=0.
REQ-015 On in_valid&&in_ready with row counter r, SHALL write element i to bank (i+r) mod NUM_PE at address r in the same cycle; r then increments.
REQ-016 In LOAD, SHALL hold every bank's read address at column 0 (bank b reads address b); the bank's same-address write bypass SHALL supply bank NUM_PE-1's row NUM_PE-1 element.
REQ-017 On accepting row NUM_PE-1 (cycle t), SHALL enter DRAIN with column counter c=0, and SHALL assert out_valid at t+1 with column 0.
REQ-018 In DRAIN, SHALL drive in_ready=0, all bank write_e=0, and each bank write_addr = bitwise inverse of its read_addr, so that the bypass never fires.
REQ-019 Bank b read address SHALL be (b - c_next) mod NUM_PE, where c_next = c+1 if out_valid&&out_ready else c.
REQ-020 out_data lane k SHALL equal bank (c+k) mod NUM_PE read_data; the rotation is combinational.
REQ-021 With out_ready held high, SHALL emit one column per cycle, NUM_PE consecutive cycles, with no bubbles.
REQ-022 With out_ready low, SHALL hold out_valid, out_data and out_last stable; the read address is held, so bank data is re-read unchanged.
REQ-023 On out_valid&&out_ready&&out_last, SHALL return to LOAD with r=0; out_valid=0 and in_ready=1 the next cycle.
REQ-024 Counters SHALL be ADDR_WIDTH bits wide and wrap modulo NUM_PE; all bank index arithmetic is modulo NUM_PE.
REQ-025 SHALL ignore in_valid in DRAIN and out_ready in LOAD.

Reset
REQ-026 While rst is high at a clock edge, SHALL set state=LOAD, r=0, c=0, out_valid=0, out_last=0, in_ready=0.
REQ-027 The first cycle after rst deasserts SHALL have in_ready=1.
REQ-028 Reset mid-LOAD or mid-DRAIN SHALL discard the partial matrix; bank contents are not cleared and SHALL NOT affect later outputs.

Structure
REQ-029 Package transpose_pkg SHALL hold the FSM state enum (LOAD, DRAIN) and the default DATA_WIDTH/NUM_PE constants.
REQ-030 SHALL instantiate NUM_PE copies of the existing bank module tranpose_memory_bank via generate: registered 1-cycle read with same-address write bypass.
REQ-031 The RTL SHALL be 120-400 lines and SHALL contain no other sub-modules.

Verification
REQ-032 NUM_PE=4, DATA_WIDTH=16, element(r,i)=16*r+i, rows sent back-to-back, out_ready=1 -> columns at t+1..t+4; column c lanes = {c, 16+c, 32+c, 48+c}; out_last only on the 4th.
REQ-033 Same matrix, out_ready toggled 1,0,0,1,... -> out_data stable while stalled; same 4 columns in order; none lost or duplicated.
REQ-034 in_valid asserted during DRAIN with junk data -> in_ready=0; drained columns unaffected; next matrix accepted after out_last handshake.
REQ-035 Two matrices sent consecutively, second element(r,i)=0x100+16*r+i -> second drain correct; no first-matrix data appears.
REQ-036 rst pulsed after 2 rows, then full matrix sent -> out_valid low until the new 4th row; output reflects only the new matrix.
REQ-037 Last row accepted with out_ready=1 already high -> column 0 lane 3 = 48 (bypass path) at t+1.
